// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, key code
// width, column strobe reset pattern and the row-priority helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int KEY_CODE_W = 4;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Lowest-index low row wins when several keys share the frozen column.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] next_strobe(input logic [3:0] strobe);
        return {strobe[2:0], strobe[3]};
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot divider for the keypad scanner: counts 0..TICK_DIV-1 and flags the
// last cycle of every slot with a one-cycle tick.
module scan_tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with tick-based press/release debounce and a
// valid/ack key event port. Define KEYPAD_REPEAT_EN to add held-key auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
`endif
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic [3:0]            rows_i,
    output logic [3:0]            columns_o,
    output logic [KEY_CODE_W-1:0] key_code_o,
    output logic                  key_valid_o,
    input  logic                  key_ack_i,
    output logic                  key_held_o,
    output logic                  overrun_o
);

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int DB_W     = $clog2(DEBOUNCE_SCANS + 1);

    logic tick;

    state_t                state, state_nxt;
    logic [1:0]            col, col_nxt;
    logic [3:0]            columns, columns_nxt;
    logic [3:0]            pattern, pattern_nxt;
    logic [DB_W-1:0]       db_cnt, db_cnt_nxt;
    logic                  held, held_nxt;
    logic [KEY_CODE_W-1:0] code, code_nxt;
    logic                  valid, valid_nxt;
    logic                  overrun, overrun_nxt;

    logic                  accept;
    logic [KEY_CODE_W-1:0] accept_code;
    logic                  event_fire;
    logic [KEY_CODE_W-1:0] event_code;

    scan_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk_50mhz),
        .reset(reset),
        .tick (tick)
    );

    assign accept_code = {lowest_low_row(pattern), col};

    assign columns_o   = columns;
    assign key_code_o  = code;
    assign key_valid_o = valid;
    assign key_held_o  = held;
    assign overrun_o   = overrun;

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state   <= SCAN;
            col     <= 2'd0;
            columns <= COL_RESET;
            pattern <= 4'hF;
            db_cnt  <= '0;
            held    <= 1'b0;
            code    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            col     <= col_nxt;
            columns <= columns_nxt;
            pattern <= pattern_nxt;
            db_cnt  <= db_cnt_nxt;
            held    <= held_nxt;
            code    <= code_nxt;
            valid   <= valid_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        columns_nxt = columns;
        pattern_nxt = pattern;
        db_cnt_nxt  = db_cnt;
        held_nxt    = held;
        accept      = 1'b0;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (rows_i == 4'hF) begin
                        col_nxt     = col + 2'd1;
                        columns_nxt = next_strobe(columns);
                    end else begin
                        // The detecting tick already counts as the first match.
                        pattern_nxt = rows_i;
                        db_cnt_nxt  = DB_W'(1);
                        state_nxt   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (rows_i == pattern) begin
                        if (db_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            accept    = 1'b1;
                            held_nxt  = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            db_cnt_nxt = db_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt   = SCAN;
                        col_nxt     = col + 2'd1;
                        columns_nxt = next_strobe(columns);
                    end
                end
                PRESSED: begin
                    if (rows_i == 4'hF) begin
                        db_cnt_nxt = DB_W'(1);
                        state_nxt  = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rows_i == 4'hF) begin
                        if (db_cnt == DB_W'(DEBOUNCE_SCANS - 1)) begin
                            held_nxt    = 1'b0;
                            state_nxt   = SCAN;
                            col_nxt     = col + 2'd1;
                            columns_nxt = next_strobe(columns);
                        end else begin
                            db_cnt_nxt = db_cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = PRESSED;
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end

        code_nxt    = code;
        valid_nxt   = valid;
        overrun_nxt = overrun;

        // An ack in the same cycle frees the slot, so the new event replaces it.
        if (event_fire) begin
            if (!valid || key_ack_i) begin
                code_nxt  = event_code;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (key_ack_i) begin
            valid_nxt = 1'b0;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0]      rep_cnt, rep_cnt_nxt;
    logic                  rep_armed, rep_armed_nxt;
    logic [REP_W-1:0]      rep_limit;
    logic                  repeat_fire;
    logic [KEY_CODE_W-1:0] held_code;

    assign rep_limit = rep_armed ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            held_code <= '0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_armed <= rep_armed_nxt;
            if (accept) begin
                held_code <= accept_code;
            end
        end
    end

    // Counting restarts whenever the key leaves PRESSED, including a glitch into RELEASE.
    always_comb begin
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
        repeat_fire   = 1'b0;
        if (state != PRESSED || state_nxt != PRESSED) begin
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
        end else if (tick) begin
            if (rep_cnt + 1'b1 == rep_limit) begin
                repeat_fire   = 1'b1;
                rep_cnt_nxt   = '0;
                rep_armed_nxt = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + 1'b1;
            end
        end
    end

    assign event_fire = accept | repeat_fire;
    assign event_code = repeat_fire ? held_code : accept_code;
`else
    assign event_fire = accept;
    assign event_code = accept_code;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from the column
// strobes, and expected timing is derived from slot arithmetic (10 cycles per slot).
module tb_keypad_scanner;

    localparam int TD = 10;
    localparam int DS = 4;
    localparam int RD = 5;
    localparam int RP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  columns;
    logic [3:0]  code;
    logic        valid;
    logic        ack;
    logic        held;
    logic        overrun;

    logic [15:0] keys;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    int          m_base_slot;
    int          m_base_col;
    int          m_key_col;
    logic        m_valid;
    logic [3:0]  m_code;
    logic        m_overrun;

    keypad_scanner #(
        .CLK_HZ        (1000),
        .SCAN_HZ       (100),
        .DEBOUNCE_SCANS(DS)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
`endif
    ) dut (
        .clk_50mhz  (clk),
        .reset      (reset),
        .rows_i     (rows),
        .columns_o  (columns),
        .key_code_o (code),
        .key_valid_o(valid),
        .key_ack_i  (ack),
        .key_held_o (held),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // A key shorts its row to its column; a row reads low when any pressed key
    // on it sits in the currently strobed column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && columns[c] === 1'b0) rows[r] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    function automatic int col_at(input int s);
        return (m_base_col + s - m_base_slot) % 4;
    endfunction

    function automatic int detect_slot(input int c, input int n0);
        int s;
        s = n0 / TD;
        if (s < m_base_slot) s = m_base_slot;
        return s + ((c - col_at(s) + 4) % 4);
    endfunction

    function automatic int tick_cyc(input int s);
        return s * TD + TD - 1;
    endfunction

    task automatic model_reset();
        m_base_slot = 0;
        m_base_col  = 0;
        m_valid     = 1'b0;
        m_code      = 4'd0;
        m_overrun   = 1'b0;
    endtask

    task automatic model_event(input int kc, input bit acked);
        if (!m_valid || acked) begin
            m_code  = 4'(kc);
            m_valid = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_columns"}, columns, 4'b1110);
        check({tag, "_code"}, code, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_held"}, held, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic press_accept(input int r, input int c, input bit ack_acc, input string tag,
                                output int ta);
        int sd;
        keys[r*4+c] = 1'b1;
        m_key_col   = c;
        sd = detect_slot(c, cyc);
        ta = tick_cyc(sd + DS - 1);
        wait_cyc(ta);
        check({tag, "_held_pre"}, held, 0);
        check({tag, "_valid_pre"}, valid, m_valid);
        ack = ack_acc;
        @(negedge clk);
        ack = 1'b0;
        model_event(r*4+c, ack_acc);
        check({tag, "_held"}, held, 1);
        check({tag, "_valid"}, valid, m_valid);
        check({tag, "_code"}, code, m_code);
        check({tag, "_overrun"}, overrun, m_overrun);
    endtask

    task automatic ack_now(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        m_valid = 1'b0;
        check({tag, "_valid"}, valid, m_valid);
        check({tag, "_code"}, code, m_code);
    endtask

    task automatic release_all(input string tag);
        int sr;
        keys = '0;
        sr = cyc / TD;
        wait_cyc(tick_cyc(sr + DS - 1));
        check({tag, "_held_last"}, held, 1);
        @(negedge clk);
        check({tag, "_held_off"}, held, 0);
        check({tag, "_valid"}, valid, m_valid);
        m_base_slot = sr + DS;
        m_base_col  = (m_key_col + 1) % 4;
    endtask

    initial begin
        int ta;
        int r;
        int c;
        int sd;
        keys  = '0;
        ack   = 1'b0;
        reset = 1'b1;
        m_key_col = 0;
        model_reset();

        do_reset();
        check_reset_outputs("reset");
        for (int n = 0; n < 80; n++) begin
            logic [3:0] ecol;
            wait_cyc(n);
            ecol = 4'hF;
            ecol[(n / TD) % 4] = 1'b0;
            check("scan_columns", columns, ecol);
            if (n % TD == 5) begin
                check("scan_valid", valid, 0);
                check("scan_held", held, 0);
                check("scan_code", code, 0);
            end
        end

`ifndef KEYPAD_REPEAT_EN
        // Clean press row 2 / col 1, held about 200 cycles.
        press_accept(2, 1, 1'b0, "clean", ta);
        check("clean_code9", code, 9);
        repeat (20) @(negedge clk);
        ack_now("clean_ack");
        repeat (150) @(negedge clk);
        check("clean_single_event", valid, 0);
        release_all("clean_rel");
        ack_now("idle_ack");

        // Bounce: low, low, high, then steady low.
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        keys[r*4+c] = 1'b1;
        sd = detect_slot(c, cyc);
        wait_cyc(tick_cyc(sd + 1) + 1);
        keys[r*4+c] = 1'b0;
        wait_cyc(tick_cyc(sd + 2) + 1);
        check("bounce_no_event", valid, 0);
        check("bounce_no_held", held, 0);
        m_base_slot = sd + 3;
        m_base_col  = (c + 1) % 4;
        press_accept(r, c, 1'b0, "bounce", ta);
        ack_now("bounce_ack");
        repeat (30) @(negedge clk);
        check("bounce_one_event", valid, 0);
        release_all("bounce_rel");

        // Overrun: two unacked presses, then a third accepted with a same-cycle ack.
        press_accept(0, 3, 1'b0, "ovr_first", ta);
        release_all("ovr_rel1");
        press_accept(3, 0, 1'b0, "ovr_second", ta);
        check("ovr_code_kept", code, 3);
        check("ovr_flag", overrun, 1);
        release_all("ovr_rel2");
        press_accept(1, 1, 1'b1, "ovr_third", ta);
        check("ovr_code5", code, 5);
        ack_now("ovr_ack");
        release_all("ovr_rel3");
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of a debounce; the still-held key is re-debounced.
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        keys[r*4+c] = 1'b1;
        sd = detect_slot(c, cyc);
        wait_cyc(tick_cyc(sd + 1) + 1);
        do_reset();
        check_reset_outputs("midreset");
        press_accept(r, c, 1'b0, "rearm", ta);
        ack_now("rearm_ack");
        release_all("rearm_rel");

        // Multi-key: rows 0 and 3 in column 2, then a column-0 key meanwhile.
        keys[3*4+2] = 1'b1;
        press_accept(0, 2, 1'b0, "multi", ta);
        check("multi_code2", code, 2);
        ack_now("multi_ack");
        keys[1*4+0] = 1'b1;
        repeat (60) @(negedge clk);
        check("multi_other_col_valid", valid, 0);
        check("multi_other_col_held", held, 1);
        check("multi_other_col_code", code, 2);
        keys[1*4+0] = 1'b0;
        release_all("multi_rel");

        // Randomised presses, hold times and acknowledge timing.
        for (int i = 0; i < 6; i++) begin
            int rr;
            int cc;
            int tta;
            rr = int'($urandom_range(0, 3));
            cc = int'($urandom_range(0, 3));
            press_accept(rr, cc, 1'($urandom_range(0, 1)), "rand", tta);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                ack_now("rand_ack");
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
            release_all("rand_rel");
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
`else
        // Auto-repeat with immediate acks, then reset while the key is still held.
        r = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        press_accept(r, c, 1'b0, "rep_accept", ta);
        ack_now("rep_ack0");
        for (int k = 0; k < 3; k++) begin
            wait_cyc(ta + (RD + RP * k) * TD);
            check("rep_valid_pre", valid, 0);
            @(negedge clk);
            model_event(r*4+c, 1'b0);
            check("rep_valid", valid, m_valid);
            check("rep_code", code, m_code);
            ack_now("rep_ack");
        end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_reset_outputs("rep_midreset");
        press_accept(r, c, 1'b0, "rep_rearm", ta);
        ack_now("rep_rearm_ack");
        release_all("rep_rel");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
